// File: rtl/rcb_port_arb.sv
// Single-port RAM arbiter for one parameter RCB: SEF reads always win the port, host writes
// wait in a small FIFO, drain on idle cycles, and are forwarded to colliding reads.
module rcb_port_arb #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 128,
  parameter int WQ_DEPTH   = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sef_rd,
  input  logic [ADDR_WIDTH-1:0]         sef_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_data_valid,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [ADDR_WIDTH-1:0]         host_wr_addr,
  input  logic [DATA_WIDTH-1:0]         host_wr_data,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic [$clog2(WQ_DEPTH):0]     wq_level,
  output logic                          wr_starved
);

  localparam int IW = $clog2(WQ_DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [ADDR_WIDTH-1:0] wq_addr [WQ_DEPTH];
  logic [DATA_WIDTH-1:0] wq_data [WQ_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  rd_gnt;
  logic                  wr_gnt;
  logic [IW-1:0]         head;

  logic                  fwd_hit_d;
  logic [DATA_WIDTH-1:0] fwd_data_d;
  logic [IW-1:0]         fwd_idx;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic [CW-1:0]         starve_left;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign level  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign head   = rd_ptr[IW-1:0];
  assign push   = host_wr_valid && !full;
  assign rd_gnt = sef_rd;
  assign wr_gnt = !sef_rd && !empty;

  assign host_wr_ready = !full;
  assign wq_level      = level;

  always_comb begin
    ram_en    = rd_gnt || wr_gnt;
    ram_we    = wr_gnt;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rd_gnt) begin
      ram_addr = sef_addr;
    end else if (wr_gnt) begin
      ram_addr  = wq_addr[head];
      ram_wdata = wq_data[head];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wq_addr[wr_ptr[IW-1:0]] <= host_wr_addr;
      wq_data[wr_ptr[IW-1:0]] <= host_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (wr_gnt) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Scan oldest to youngest so the last match (youngest write) wins; same-cycle push is excluded.
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    fwd_idx    = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      fwd_idx = head + IW'(i);
      if ((PW'(i) < level) && (wq_addr[fwd_idx] == sef_addr)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = wq_data[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld   <= 1'b0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      rd_vld <= sef_rd;
      if (sef_rd) begin
        fwd_hit  <= fwd_hit_d;
        fwd_data <= fwd_data_d;
      end
    end
  end

  assign rd_sel        = fwd_hit ? fwd_data : ram_rdata;
  assign rd_data       = rd_vld ? rd_sel : rd_hold;
  assign rd_data_valid = rd_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_hold <= '0;
    end else if (rd_vld) begin
      rd_hold <= rd_sel;
    end
  end

  // Down-counter: reloads whenever writes are not being blocked, flags at terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_left <= CW'(STARVE_MAX);
    end else if (sef_rd && !empty) begin
      if (starve_left != '0) starve_left <= starve_left - 1'b1;
    end else begin
      starve_left <= CW'(STARVE_MAX);
    end
  end

  assign wr_starved = (starve_left == '0);

endmodule

// File: tb/tb_rcb_port_arb.sv
// Self-checking bench for rcb_port_arb: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rcb_port_arb;

  localparam int AW = 14;
  localparam int DW = 128;
  localparam int WQ_DEPTH = 4;
  localparam int STARVE_MAX = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sef_rd = 1'b0;
  logic [AW-1:0] sef_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          host_wr_valid = 1'b0;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [2:0]    wq_level;
  logic          wr_starved;

  int errors = 0;
  int checks = 0;

  rcb_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WQ_DEPTH(WQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .sef_rd(sef_rd), .sef_addr(sef_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .wq_level(wq_level), .wr_starved(wr_starved)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] def_word(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'hA5A5_0000 | 32'(a);
    return {w, ~w, w, ~w};
  endfunction

  // RAM behind the port: 1-cycle synchronous read, unwritten locations read a fixed pattern.
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] = ram_wdata;
      else ram_rdata <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : def_word(ram_addr);
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue as a list of pending writes plus the committed memory image.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           q[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic          pend_valid = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] last_rd = '0;
  int            starve = 0;
  int            size0;
  logic [DW-1:0] look;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      pend_valid = 1'b0;
      pend_data  = '0;
      last_rd    = '0;
      starve     = 0;
    end else begin
      size0 = q.size();
      check("m_ready", host_wr_ready, size0 < WQ_DEPTH);
      check("m_level", wq_level, size0);
      check("m_starved", wr_starved, starve >= STARVE_MAX);
      check("m_rvalid", rd_data_valid, pend_valid);
      check("m_rdata", rd_data, pend_valid ? pend_data : last_rd);
      if (sef_rd) begin
        check("m_en_rd", ram_en, 1'b1);
        check("m_we_rd", ram_we, 1'b0);
        check("m_addr_rd", ram_addr, sef_addr);
      end else if (size0 > 0) begin
        check("m_en_wr", ram_en, 1'b1);
        check("m_we_wr", ram_we, 1'b1);
        check("m_addr_wr", ram_addr, q[0].a);
        check("m_wdata_wr", ram_wdata, q[0].d);
      end else begin
        check("m_en_idle", ram_en, 1'b0);
      end

      if (pend_valid) last_rd = pend_data;
      pend_valid = sef_rd;
      if (sef_rd) begin
        look = model_mem.exists(sef_addr) ? model_mem[sef_addr] : def_word(sef_addr);
        foreach (q[i]) if (q[i].a == sef_addr) look = q[i].d;
        pend_data = look;
      end
      if (sef_rd && size0 > 0) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
      else starve = 0;
      if (!sef_rd && size0 > 0) begin
        model_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (host_wr_valid && size0 < WQ_DEPTH) q.push_back('{a: host_wr_addr, d: host_wr_data});
    end
  end

  task automatic step(input logic rd, input logic [AW-1:0] ra, input logic wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    @(posedge clk);
    #1;
    sef_rd = rd;
    sef_addr = ra;
    host_wr_valid = wv;
    host_wr_addr = wa;
    host_wr_data = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d1, d2, d3, d5;
    d1 = 128'hD1D1_0000_0000_0000_0000_0000_0000_0001;
    d2 = 128'hD2D2_0000_0000_0000_0000_0000_0000_0002;
    d3 = 128'hD3D3_0000_0000_0000_0000_0000_0000_0003;
    d5 = 128'hD5D5_0000_0000_0000_0000_0000_0000_0005;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_rvalid", rd_data_valid, 1'b0);
    check("rst_rdata", rd_data, '0);
    check("rst_ready", host_wr_ready, 1'b1);
    check("rst_level", wq_level, 3'd0);
    check("rst_starved", wr_starved, 1'b0);

    // Single write on an idle bus.
    step(1'b0, '0, 1'b1, 14'h10, 128'h55);
    check("w1_level_push", wq_level, 3'd0);
    idle();
    check("w1_we", ram_we, 1'b1);
    check("w1_addr", ram_addr, 14'h10);
    check("w1_wdata", ram_wdata, 128'h55);
    check("w1_level", wq_level, 3'd1);
    idle();
    check("w1_level_after", wq_level, 3'd0);

    // Fill the queue under continuous reads; extra pushes are refused.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, AW'(14'h200 + k), 1'b1, AW'(14'h100 + k), DW'(32'hD00 + k));
      check("fill_no_we", ram_we, 1'b0);
    end
    check("fill_level", wq_level, 3'd4);
    check("fill_ready", host_wr_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle();
      check("drain_we", ram_we, 1'b1);
      check("drain_addr", ram_addr, AW'(14'h100 + k));
      check("drain_wdata", ram_wdata, DW'(32'hD00 + k));
    end
    idle();
    check("drain_done_en", ram_en, 1'b0);
    check("drain_done_level", wq_level, 3'd0);

    // Youngest queued write to the same address is forwarded.
    step(1'b1, 14'h50, 1'b1, 14'h20, d1);
    step(1'b1, 14'h51, 1'b1, 14'h20, d2);
    step(1'b1, 14'h20, 1'b0, '0, '0);
    step(1'b1, 14'h52, 1'b0, '0, '0);
    check("fwd_valid", rd_data_valid, 1'b1);
    check("fwd_data", rd_data, d2);
    repeat (4) idle();

    // Same-cycle push is not forwarded.
    step(1'b1, 14'h30, 1'b1, 14'h30, d3);
    idle();
    check("nofwd_valid", rd_data_valid, 1'b1);
    check("nofwd_data", rd_data, def_word(14'h30));
    check("nofwd_we", ram_we, 1'b1);
    check("nofwd_addr", ram_addr, 14'h30);
    check("nofwd_wdata", ram_wdata, d3);
    idle();

    // Starvation flag.
    step(1'b1, 14'h60, 1'b1, 14'h61, d5);
    for (int j = 1; j <= 16; j++) begin
      step(1'b1, 14'h60, 1'b0, '0, '0);
      if (j == 15) check("starve_15", wr_starved, 1'b0);
      if (j == 16) check("starve_16", wr_starved, 1'b1);
    end
    idle();
    check("starve_grant_we", ram_we, 1'b1);
    check("starve_grant_flag", wr_starved, 1'b1);
    idle();
    check("starve_cleared", wr_starved, 1'b0);

    // Reset with writes queued and a read in flight.
    step(1'b1, 14'h70, 1'b1, 14'h71, 128'h71);
    step(1'b1, 14'h70, 1'b1, 14'h72, 128'h72);
    step(1'b1, 14'h70, 1'b1, 14'h73, 128'h73);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    sef_rd = 1'b0;
    host_wr_valid = 1'b0;
    #1;
    check("arst_rvalid", rd_data_valid, 1'b0);
    check("arst_rdata", rd_data, '0);
    check("arst_level", wq_level, 3'd0);
    check("arst_en", ram_en, 1'b0);
    check("arst_starved", wr_starved, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      idle();
      check("arst_no_commit", ram_en, 1'b0);
    end

    // Randomized traffic on a small address window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sef_rd = 1'b0;
        host_wr_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
      end else begin
        step($urandom_range(0, 99) < 55, AW'($urandom_range(0, 15)),
             $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
             {$urandom(), $urandom(), $urandom(), $urandom()});
      end
    end
    repeat (8) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
